// File: rtl/drc_frm_pooler.sv
// drc_frm_pooler: pools each 2^SCALE_LOG2 x 2^SCALE_LOG2 block of a raster stream into one pixel (avg or max)
// Latency: 1 cycle from acceptance of a block's last pixel to o_pxl_vld
// Backpressure: i_pxl_rdy = ~o_pxl_vld | o_pxl_rdy; a stalled output register holds the input
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_mode                 0 = average, 1 = max; sampled on the first pixel of each frame
//   i_pxl_dat/last/vld/rdy   input raster stream, i_pxl_last marks the final pixel
//   o_pxl_dat/last/vld/rdy   pooled stream, o_pxl_last on the frame's final pooled pixel
//   frm_err                  one-cycle pulse when i_pxl_last disagrees with the frame size
//
// Optional feature: define DRC_POOLER_ROUND_EN to round the average half up instead of
// truncating (accumulator widened by one bit to hold the rounding constant).
module drc_frm_pooler #(
   parameter int PXL_W      = 8,
   parameter int COL_NUM    = 640,
   parameter int ROW_NUM    = 480,
   parameter int SCALE_LOG2 = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_mode,
   input  logic [PXL_W-1:0] i_pxl_dat,
   input  logic             i_pxl_last,
   input  logic             i_pxl_vld,
   output logic             i_pxl_rdy,
   output logic [PXL_W-1:0] o_pxl_dat,
   output logic             o_pxl_last,
   output logic             o_pxl_vld,
   input  logic             o_pxl_rdy,
   output logic             frm_err
);

`ifdef DRC_POOLER_ROUND_EN
   localparam int ACC_W = PXL_W + 2*SCALE_LOG2 + 1;
`else
   localparam int ACC_W = PXL_W + 2*SCALE_LOG2;
`endif
   localparam int ACC_NUM = COL_NUM >> SCALE_LOG2;
   localparam int COL_W   = $clog2(COL_NUM);
   localparam int ROW_W   = $clog2(ROW_NUM);
   localparam int IDX_W   = (ACC_NUM > 1) ? $clog2(ACC_NUM) : 1;

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic             mode;

   // One partial result per block column of the current block row
   logic [ACC_W-1:0] acc_mem [ACC_NUM];

   logic             fire;
   logic             at_origin;
   logic             col_end;
   logic             row_end;
   logic             frm_end;
   logic             early_last;
   logic             blk_first;
   logic             blk_last;
   logic             mode_eff;
   logic             emit;
   logic [IDX_W-1:0] idx;
   logic [ACC_W-1:0] acc_rd;
   logic [ACC_W-1:0] pxl_ext;
   logic [ACC_W-1:0] acc_sum;
   logic [ACC_W-1:0] acc_max;
   logic [ACC_W-1:0] acc_nxt;
   logic [PXL_W-1:0] avg_res;
   logic [PXL_W-1:0] res;

   assign i_pxl_rdy  = ~o_pxl_vld | o_pxl_rdy;
   assign fire       = i_pxl_vld & i_pxl_rdy;

   assign at_origin  = (col == '0) && (row == '0);
   assign col_end    = (col == COL_W'(COL_NUM-1));
   assign row_end    = (row == ROW_W'(ROW_NUM-1));
   assign frm_end    = col_end & row_end;
   assign early_last = i_pxl_last & ~frm_end;

   assign blk_first  = (col[SCALE_LOG2-1:0] == '0) && (row[SCALE_LOG2-1:0] == '0);
   assign blk_last   = (&col[SCALE_LOG2-1:0]) & (&row[SCALE_LOG2-1:0]);

   // Pixel (0,0) always starts a block, so the registered mode is only consulted
   // from the second pixel on; using cfg_mode there keeps the first frame coherent.
   assign mode_eff   = at_origin ? cfg_mode : mode;
   assign emit       = fire & blk_last;

   assign idx        = IDX_W'(col >> SCALE_LOG2);
   assign acc_rd     = acc_mem[idx];
   assign pxl_ext    = ACC_W'(i_pxl_dat);
   assign acc_sum    = acc_rd + pxl_ext;
   assign acc_max    = (acc_rd > pxl_ext) ? acc_rd : pxl_ext;

   always_comb begin
      acc_nxt = acc_sum;
      if (blk_first) begin
         acc_nxt = pxl_ext;
      end else if (mode_eff) begin
         acc_nxt = acc_max;
      end
   end

   // The block sum of N*N pixels divided by N*N always fits PXL_W, so the cast
   // only drops bits that are guaranteed zero.
`ifdef DRC_POOLER_ROUND_EN
   assign avg_res = PXL_W'((acc_sum + ACC_W'(1 << (2*SCALE_LOG2-1))) >> (2*SCALE_LOG2));
`else
   assign avg_res = PXL_W'(acc_sum >> (2*SCALE_LOG2));
`endif
   assign res     = mode_eff ? PXL_W'(acc_max) : avg_res;

   // Counters, mode, output register and error pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col        <= '0;
         row        <= '0;
         mode       <= 1'b0;
         o_pxl_vld  <= 1'b0;
         o_pxl_last <= 1'b0;
         o_pxl_dat  <= '0;
         frm_err    <= 1'b0;
      end else begin
         frm_err <= 1'b0;
         if (fire) begin
            // An early i_pxl_last abandons the frame: partial blocks are simply
            // overwritten by the next frame's first pixels.
            if (frm_end | early_last) begin
               col <= '0;
               row <= '0;
            end else if (col_end) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
            if (at_origin) begin
               mode <= cfg_mode;
            end
            frm_err <= early_last | (frm_end & ~i_pxl_last);
         end
         // Input is only accepted when the output slot is free or draining, so an
         // emit can never overwrite an untransferred pixel.
         if (emit) begin
            o_pxl_vld  <= 1'b1;
            o_pxl_dat  <= res;
            o_pxl_last <= frm_end;
         end else if (o_pxl_rdy) begin
            o_pxl_vld  <= 1'b0;
         end
      end
   end

   // Accumulator contents need no reset: each block overwrites on its first pixel
   always_ff @(posedge clk) begin
      if (fire) begin
         acc_mem[idx] <= acc_nxt;
      end
   end

endmodule

// File: tb/tb_drc_frm_pooler.sv
`timescale 1ns/1ps
module tb_drc_frm_pooler;
   localparam int CN = 4;
   localparam int RN = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_mode = 1'b0;
   logic [7:0] i_dat = 8'd0;
   logic       i_last = 1'b0;
   logic       i_vld = 1'b0;
   logic       sel2 = 1'b0;
   logic       o_rdy = 1'b1;
   logic       rdy_rand = 1'b0;

   logic       vld1, vld2;
   logic       i_rdy1, o_vld1, o_last1, err1;
   logic [7:0] o_dat1;
   logic       i_rdy2, o_vld2, o_last2, err2;
   logic [7:0] o_dat2;

   int checks = 0;
   int errors = 0;
   int err_cnt = 0;
   int err_cnt2 = 0;
   int px[$];
   int exp_dat[$];
   bit exp_last[$];
   int got_dat[$];
   bit got_last[$];
   int got2_dat[$];
   bit got2_last[$];

   assign vld1 = i_vld & ~sel2;
   assign vld2 = i_vld & sel2;

   always #5 clk = ~clk;

   drc_frm_pooler #(.PXL_W(8), .COL_NUM(CN), .ROW_NUM(RN), .SCALE_LOG2(1)) dut (
      .clk(clk), .rst(rst), .cfg_mode(cfg_mode),
      .i_pxl_dat(i_dat), .i_pxl_last(i_last), .i_pxl_vld(vld1), .i_pxl_rdy(i_rdy1),
      .o_pxl_dat(o_dat1), .o_pxl_last(o_last1), .o_pxl_vld(o_vld1), .o_pxl_rdy(o_rdy),
      .frm_err(err1)
   );

   drc_frm_pooler #(.PXL_W(8), .COL_NUM(CN), .ROW_NUM(RN), .SCALE_LOG2(2)) dut2 (
      .clk(clk), .rst(rst), .cfg_mode(cfg_mode),
      .i_pxl_dat(i_dat), .i_pxl_last(i_last), .i_pxl_vld(vld2), .i_pxl_rdy(i_rdy2),
      .o_pxl_dat(o_dat2), .o_pxl_last(o_last2), .o_pxl_vld(o_vld2), .o_pxl_rdy(o_rdy),
      .frm_err(err2)
   );

   // Reference: pool the frame block by block in raster order of block completion
   task automatic model(input int s, input bit mode);
      int k, sum, mx, v, rnd;
      k = 1 << s;
`ifdef DRC_POOLER_ROUND_EN
      rnd = (k * k) / 2;
`else
      rnd = 0;
`endif
      for (int br = 0; br < RN / k; br++) begin
         for (int bc = 0; bc < CN / k; bc++) begin
            sum = 0;
            mx  = 0;
            for (int dy = 0; dy < k; dy++) begin
               for (int dx = 0; dx < k; dx++) begin
                  v = px[(br*k + dy)*CN + bc*k + dx];
                  sum += v;
                  if (v > mx) mx = v;
               end
            end
            exp_dat.push_back(mode ? mx : (sum + rnd) / (k * k));
            exp_last.push_back((br == RN/k - 1) && (bc == CN/k - 1));
         end
      end
   endtask

   task automatic fill_ramp();
      px.delete();
      for (int i = 0; i < CN*RN; i++) px.push_back(i);
   endtask

   task automatic fill_rand();
      px.delete();
      for (int i = 0; i < CN*RN; i++) px.push_back(int'($urandom_range(0, 255)));
   endtask

   task automatic clear_q();
      exp_dat.delete(); exp_last.delete();
      got_dat.delete(); got_last.delete();
      got2_dat.delete(); got2_last.delete();
   endtask

   // Collects output transfers and frm_err pulses; checks output stability under stall
   task automatic monitor();
      bit stall = 1'b0;
      int pd = 0;
      bit pl = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               checks++;
               if (o_vld1 !== 1'b1 || int'(o_dat1) !== pd || o_last1 !== pl) begin
                  errors++;
                  $display("FAIL hold: vld=%b dat=%0d last=%b, required vld=1 dat=%0d last=%b",
                           o_vld1, o_dat1, o_last1, pd, pl);
               end
            end
            stall = o_vld1 & ~o_rdy;
            pd = int'(o_dat1);
            pl = o_last1;
            if (o_vld1 && o_rdy) begin got_dat.push_back(int'(o_dat1)); got_last.push_back(o_last1); end
            if (o_vld2 && o_rdy) begin got2_dat.push_back(int'(o_dat2)); got2_last.push_back(o_last2); end
            if (err1) err_cnt++;
            if (err2) err_cnt2++;
         end
      end
   endtask

   task automatic rdy_gen();
      forever begin
         @(posedge clk); #1;
         if (rdy_rand) o_rdy = 1'($urandom_range(0, 1));
      end
   endtask

   // Sends px[0..n-1]; last_idx < 0 means i_pxl_last is never raised
   task automatic send(input int n, input int last_idx, input bit mode, input bit toggle);
      bit ok;
      for (int i = 0; i < n; i++) begin
         i_dat  = 8'(px[i]);
         i_last = (i == last_idx);
         i_vld  = 1'b1;
         if (i == 0) cfg_mode = mode;
         else if (toggle) cfg_mode = 1'($urandom_range(0, 1));
         ok = 1'b0;
         for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            ok = sel2 ? i_rdy2 : i_rdy1;
            @(posedge clk); #1;
         end
         if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: pixel %0d not accepted in 200 cycles, required acceptance", i);
         end
      end
      i_vld = 1'b0;
      i_last = 1'b0;
   endtask

   task automatic drain();
      rdy_rand = 1'b0;
      o_rdy = 1'b1;
      repeat (10) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (o_vld1 !== 1'b0) begin errors++; $display("FAIL rst_vld: got %b required 0", o_vld1); end
      checks++; if (o_dat1 !== 8'd0) begin errors++; $display("FAIL rst_dat: got %0d required 0", o_dat1); end
      checks++; if (o_last1 !== 1'b0) begin errors++; $display("FAIL rst_last: got %b required 0", o_last1); end
      checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL rst_err: got %b required 0", err1); end
      checks++; if (i_rdy1 !== 1'b1) begin errors++; $display("FAIL rst_rdy: got %b required 1", i_rdy1); end
      checks++; if (o_vld2 !== 1'b0) begin errors++; $display("FAIL rst_vld2: got %b required 0", o_vld2); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_pool(input bit mode);
      int e0;
      clear_q();
      fill_ramp();
      model(1, mode);
      send(CN*RN, CN*RN-1, mode, 1'b0);
      drain();
      checks++;
      if (got_dat.size() !== exp_dat.size()) begin
         errors++; $display("FAIL pool%0d_count: got %0d required %0d", mode, got_dat.size(), exp_dat.size());
      end
      for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
         checks++;
         if (got_dat[i] !== exp_dat[i] || got_last[i] !== exp_last[i]) begin
            errors++;
            $display("FAIL pool%0d_out%0d: got %0d/last %b required %0d/last %b",
                     mode, i, got_dat[i], got_last[i], exp_dat[i], exp_last[i]);
         end
      end
`ifdef DRC_POOLER_ROUND_EN
      e0 = mode ? 5 : 3;
`else
      e0 = mode ? 5 : 2;
`endif
      if (got_dat.size() > 0) begin
         checks++;
         if (got_dat[0] !== e0) begin errors++; $display("FAIL pool%0d_first: got %0d required %0d", mode, got_dat[0], e0); end
      end
      checks++;
      if (err_cnt !== 0) begin errors++; $display("FAIL pool%0d_err: got %0d pulses required 0", mode, err_cnt); end
   endtask

   task automatic test_stall();
      clear_q();
      fill_ramp();
      model(1, 1'b0);
      fork
         send(CN*RN, CN*RN-1, 1'b0, 1'b0);
         begin
            bit seen = 1'b0;
            for (int c = 0; c < 100 && !seen; c++) begin
               @(posedge clk); #1;
               seen = o_vld1;
            end
            if (!seen) begin
               checks++; errors++; $display("FAIL stall_wait: o_pxl_vld never rose, required 1");
            end
            o_rdy = 1'b0;
            repeat (5) begin
               @(negedge clk);
               checks++;
               if (int'(o_dat1) !== exp_dat[0] || i_rdy1 !== 1'b0) begin
                  errors++;
                  $display("FAIL stall_hold: dat=%0d rdy=%b required dat=%0d rdy=0", o_dat1, i_rdy1, exp_dat[0]);
               end
            end
            @(posedge clk); #1;
            o_rdy = 1'b1;
         end
      join
      drain();
      checks++;
      if (got_dat.size() !== exp_dat.size()) begin
         errors++; $display("FAIL stall_count: got %0d required %0d", got_dat.size(), exp_dat.size());
      end
      for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
         checks++;
         if (got_dat[i] !== exp_dat[i] || got_last[i] !== exp_last[i]) begin
            errors++;
            $display("FAIL stall_out%0d: got %0d/last %b required %0d/last %b",
                     i, got_dat[i], got_last[i], exp_dat[i], exp_last[i]);
         end
      end
   endtask

   task automatic test_early_last();
      int base;
      clear_q();
      fill_ramp();
      model(1, 1'b0);
      base = err_cnt;
      send(7, 6, 1'b0, 1'b0);
      drain();
      checks++;
      if (got_dat.size() !== 1) begin errors++; $display("FAIL early_count: got %0d required 1", got_dat.size()); end
      else begin
         checks++;
         if (got_dat[0] !== exp_dat[0] || got_last[0] !== 1'b0) begin
            errors++; $display("FAIL early_out: got %0d/last %b required %0d/last 0", got_dat[0], got_last[0], exp_dat[0]);
         end
      end
      checks++;
      if (err_cnt - base !== 1) begin errors++; $display("FAIL early_err: got %0d pulses required 1", err_cnt - base); end
      got_dat.delete(); got_last.delete();
      send(CN*RN, CN*RN-1, 1'b0, 1'b0);
      drain();
      checks++;
      if (got_dat.size() !== exp_dat.size()) begin
         errors++; $display("FAIL early_next_count: got %0d required %0d", got_dat.size(), exp_dat.size());
      end
      for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
         checks++;
         if (got_dat[i] !== exp_dat[i] || got_last[i] !== exp_last[i]) begin
            errors++;
            $display("FAIL early_next%0d: got %0d/last %b required %0d/last %b",
                     i, got_dat[i], got_last[i], exp_dat[i], exp_last[i]);
         end
      end
      checks++;
      if (err_cnt - base !== 1) begin errors++; $display("FAIL early_next_err: got %0d pulses required 1", err_cnt - base); end
   endtask

   task automatic test_missing_last();
      int base;
      clear_q();
      fill_rand();
      model(1, 1'b0);
      base = err_cnt;
      send(CN*RN, -1, 1'b0, 1'b0);
      drain();
      checks++;
      if (got_dat.size() !== exp_dat.size()) begin
         errors++; $display("FAIL nolast_count: got %0d required %0d", got_dat.size(), exp_dat.size());
      end
      for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
         checks++;
         if (got_dat[i] !== exp_dat[i] || got_last[i] !== exp_last[i]) begin
            errors++;
            $display("FAIL nolast_out%0d: got %0d/last %b required %0d/last %b",
                     i, got_dat[i], got_last[i], exp_dat[i], exp_last[i]);
         end
      end
      checks++;
      if (err_cnt - base !== 1) begin errors++; $display("FAIL nolast_err: got %0d pulses required 1", err_cnt - base); end
   endtask

   task automatic test_reset_mid();
      clear_q();
      fill_ramp();
      send(9, -1, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      checks++;
      if (o_vld1 !== 1'b0 || o_dat1 !== 8'd0 || o_last1 !== 1'b0 || err1 !== 1'b0) begin
         errors++;
         $display("FAIL midrst_out: vld=%b dat=%0d last=%b err=%b required all 0", o_vld1, o_dat1, o_last1, err1);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      clear_q();
      model(1, 1'b0);
      send(CN*RN, CN*RN-1, 1'b0, 1'b0);
      drain();
      checks++;
      if (got_dat.size() !== exp_dat.size()) begin
         errors++; $display("FAIL midrst_count: got %0d required %0d", got_dat.size(), exp_dat.size());
      end
      for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
         checks++;
         if (got_dat[i] !== exp_dat[i] || got_last[i] !== exp_last[i]) begin
            errors++;
            $display("FAIL midrst_out%0d: got %0d/last %b required %0d/last %b",
                     i, got_dat[i], got_last[i], exp_dat[i], exp_last[i]);
         end
      end
   endtask

   task automatic test_random();
      int base;
      bit m;
      clear_q();
      base = err_cnt;
      rdy_rand = 1'b1;
      for (int f = 0; f < 8; f++) begin
         fill_rand();
         m = 1'($urandom_range(0, 1));
         model(1, m);
         rdy_rand = 1'b1;
         send(CN*RN, CN*RN-1, m, 1'b1);
      end
      drain();
      checks++;
      if (got_dat.size() !== exp_dat.size()) begin
         errors++; $display("FAIL rand_count: got %0d required %0d", got_dat.size(), exp_dat.size());
      end
      for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
         checks++;
         if (got_dat[i] !== exp_dat[i] || got_last[i] !== exp_last[i]) begin
            errors++;
            $display("FAIL rand_out%0d: got %0d/last %b required %0d/last %b",
                     i, got_dat[i], got_last[i], exp_dat[i], exp_last[i]);
         end
      end
      checks++;
      if (err_cnt !== base) begin errors++; $display("FAIL rand_err: got %0d pulses required 0", err_cnt - base); end
   endtask

   task automatic test_scale4();
      clear_q();
      sel2 = 1'b1;
      px.delete();
      for (int i = 0; i < CN*RN; i++) px.push_back(255);
      model(2, 1'b0);
      send(CN*RN, CN*RN-1, 1'b0, 1'b1);
      fill_rand();
      model(2, 1'b0);
      send(CN*RN, CN*RN-1, 1'b0, 1'b1);
      fill_rand();
      model(2, 1'b1);
      send(CN*RN, CN*RN-1, 1'b1, 1'b1);
      drain();
      sel2 = 1'b0;
      checks++;
      if (got2_dat.size() !== exp_dat.size()) begin
         errors++; $display("FAIL s4_count: got %0d required %0d", got2_dat.size(), exp_dat.size());
      end
      for (int i = 0; i < exp_dat.size() && i < got2_dat.size(); i++) begin
         checks++;
         if (got2_dat[i] !== exp_dat[i] || got2_last[i] !== exp_last[i]) begin
            errors++;
            $display("FAIL s4_out%0d: got %0d/last %b required %0d/last %b",
                     i, got2_dat[i], got2_last[i], exp_dat[i], exp_last[i]);
         end
      end
      if (got2_dat.size() > 0) begin
         checks++;
         if (got2_dat[0] !== 255) begin errors++; $display("FAIL s4_white: got %0d required 255", got2_dat[0]); end
      end
      checks++;
      if (err_cnt2 !== 0) begin errors++; $display("FAIL s4_err: got %0d pulses required 0", err_cnt2); end
   endtask

   initial begin
      fork
         monitor();
         rdy_gen();
      join_none
      test_reset();
      test_pool(1'b0);
      test_pool(1'b1);
      test_stall();
      test_early_last();
      test_missing_last();
      test_reset_mid();
      test_random();
      test_scale4();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
